hello_scroller: RTL and testbench



---
 rtl/hello_scroller.sv | 116 +++++++++++
 tb/tb_hello_scroller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hello_scroller.sv
// Scrolling "HELLO" message driver for a multiplexed, active-low 7-segment display.
// A prescaled step tick moves the message offset; a free-running refresh counter walks the digits.
module hello_scroller #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int STEP_DIV    = 50000000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       blank,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [$clog2(MSG_LEN)-1:0] pos,
  output logic                       wrap
);

  localparam int POS_W = $clog2(MSG_LEN);
  localparam int D_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(STEP_DIV - 1);
  localparam logic [RC_W-1:0]  REF_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [D_W-1:0]   D_LAST    = D_W'(NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(MSG_LEN - 1);
  localparam logic [4:0]       MSG_LEN_X = 5'(MSG_LEN);

  localparam logic [6:0] SEG_H     = 7'b1001000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [SC_W-1:0] step_cnt;
  logic [RC_W-1:0] ref_cnt;
  logic [D_W-1:0]  digit;
  logic            tick;
  logic            ref_tc;
  logic [4:0]      idx_sum;
  logic [4:0]      idx;
  logic [6:0]      char_seg;

  assign tick   = en && (step_cnt == STEP_LAST);
  assign ref_tc = (ref_cnt == REF_LAST);

  // 5-bit sum holds pos+digit up to 15+7 without truncation; it is always < 2*MSG_LEN,
  // so one conditional subtract is a full modulo.
  assign idx_sum = 5'(pos) + 5'(digit);
  assign idx     = (idx_sum >= MSG_LEN_X) ? (idx_sum - MSG_LEN_X) : idx_sum;

  always_comb begin
    char_seg = SEG_BLANK;
    case (idx)
      5'd0:       char_seg = SEG_H;
      5'd1:       char_seg = SEG_E;
      5'd2, 5'd3: char_seg = SEG_L;
      5'd4:       char_seg = SEG_O;
      default:    char_seg = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_cnt <= '0;
    end else if (en) begin
      step_cnt <= tick ? '0 : step_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos  <= '0;
      wrap <= 1'b0;
    end else if (tick) begin
      if (!dir) begin
        pos  <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
        wrap <= (pos == POS_LAST);
      end else begin
        pos  <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
        wrap <= (pos == '0);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_cnt <= '0;
      digit   <= '0;
    end else begin
      ref_cnt <= ref_tc ? '0 : ref_cnt + RC_W'(1);
      if (ref_tc) begin
        digit <= (digit == D_LAST) ? '0 : digit + D_W'(1);
      end
    end
  end

  // Output register samples pre-edge digit/pos, so counter updates show one edge later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << digit);
      seg <= char_seg;
    end
  end

endmodule

// File: tb/tb_hello_scroller.sv
// Bench for hello_scroller: an arithmetic model (edge counts, enabled-cycle counts, modulo)
// predicts every output each cycle; directed phases pin the model with literal values.
module tb_hello_scroller;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int SD = 4;
  localparam int RD = 2;

  localparam logic [6:0] C_H  = 7'b1001000;
  localparam logic [6:0] C_E  = 7'b0110000;
  localparam logic [6:0] C_L  = 7'b1110001;
  localparam logic [6:0] C_O  = 7'b0000001;
  localparam logic [6:0] C_BL = 7'b1111111;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic dir = 1'b0;
  logic blank = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [2:0]    pos;
  logic          wrap;

  int vectors = 0;
  int misc = 0;

  int          cyc = 0;
  int          en_total = 0;
  int          m_pos = 0;
  int          dg;
  logic        m_wrap = 1'b0;
  logic [3:0]  exp_an = 4'hf;
  logic [6:0]  exp_seg = 7'h7f;

  logic [6:0] shown [ND];
  int wraps;

  logic [3:0] mux_an  [9] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                              4'b0111, 4'b0111, 4'b1110};
  logic [6:0] mux_seg [9] = '{C_H, C_H, C_E, C_E, C_L, C_L, C_L, C_L, C_H};

  hello_scroller #(
    .NUM_DIGITS(ND), .MSG_LEN(ML), .STEP_DIV(SD), .REFRESH_DIV(RD)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .blank(blank),
    .seg(seg), .an(an), .pos(pos), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] msg_seg(input int i);
    case (i)
      0:       return C_H;
      1:       return C_E;
      2, 3:    return C_L;
      4:       return C_O;
      default: return C_BL;
    endcase
  endfunction

  // Model: digit = (edges since reset / RD) mod ND; a step happens on every SD-th enabled edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc = 0; en_total = 0; m_pos = 0; m_wrap = 1'b0;
      exp_an = 4'hf; exp_seg = C_BL;
    end else begin
      dg = (cyc / RD) % ND;
      if (blank) begin
        exp_an = 4'hf; exp_seg = C_BL;
      end else begin
        exp_an = ~(4'b0001 << dg);
        exp_seg = msg_seg((m_pos + dg) % ML);
      end
      m_wrap = 1'b0;
      if (en) begin
        en_total++;
        if (en_total % SD == 0) begin
          if (!dir) begin
            m_wrap = (m_pos == ML - 1);
            m_pos = (m_pos + 1) % ML;
          end else begin
            m_wrap = (m_pos == 0);
            m_pos = (m_pos + ML - 1) % ML;
          end
        end
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      misc++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_an", int'(an), int'(exp_an));
    chk("model_seg", int'(seg), int'(exp_seg));
    chk("model_pos", int'(pos), m_pos);
    chk("model_wrap", int'(wrap), int'(m_wrap));
  end

  // Runs with en=0 so pos is frozen; records which segment pattern each digit shows.
  task automatic capture();
    for (int i = 0; i < ND; i++) shown[i] = 7'h00;
    for (int k = 0; k < 2 * RD * ND; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < ND; i++)
        if (an == ~(4'b0001 << i)) shown[i] = seg;
    end
    #1;
  endtask

  task automatic run_count_wraps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (wrap) wraps++;
    end
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", int'(an), 'hf);
    chk("rst_seg", int'(seg), 'h7f);
    chk("rst_pos", int'(pos), 0);
    chk("rst_wrap", int'(wrap), 0);

    @(posedge clk); #2 rstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("mux_an", int'(an), int'(mux_an[k]));
      chk("mux_seg", int'(seg), int'(mux_seg[k]));
      chk("mux_pos", int'(pos), 0);
    end
    #1;

    en = 1'b1; dir = 1'b0; wraps = 0;
    run_count_wraps(16);
    en = 1'b0;
    chk("left_pos4", int'(pos), 4);
    capture();
    chk("pos4_d0", int'(shown[0]), int'(C_O));
    chk("pos4_d1", int'(shown[1]), int'(C_BL));
    chk("pos4_d2", int'(shown[2]), int'(C_BL));
    chk("pos4_d3", int'(shown[3]), int'(C_BL));

    en = 1'b1;
    run_count_wraps(8);
    en = 1'b0;
    chk("left_pos6", int'(pos), 6);
    capture();
    chk("pos6_d0", int'(shown[0]), int'(C_BL));
    chk("pos6_d1", int'(shown[1]), int'(C_BL));
    chk("pos6_d2", int'(shown[2]), int'(C_H));
    chk("pos6_d3", int'(shown[3]), int'(C_E));

    en = 1'b1;
    run_count_wraps(8);
    en = 1'b0;
    chk("left_wrap_pos", int'(pos), 0);
    chk("left_wrap_count", wraps, 1);

    dir = 1'b1; en = 1'b1; wraps = 0;
    run_count_wraps(4);
    en = 1'b0;
    chk("right_pos7", int'(pos), 7);
    chk("right_wrap_count", wraps, 1);
    capture();
    chk("pos7_d0", int'(shown[0]), int'(C_BL));
    chk("pos7_d1", int'(shown[1]), int'(C_H));

    dir = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    #2 en = 1'b1;
    chk("gate_start_pos", int'(pos), 0);
    repeat (3) @(posedge clk);
    #2 en = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("gate_hold_pos", int'(pos), 0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("gate_tick_pos", int'(pos), 1);
    #1;

    blank = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("blank_an", int'(an), 'hf);
      chk("blank_seg", int'(seg), 'h7f);
    end
    chk("blank_pos", int'(pos), 3);
    #1 blank = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_an", int'(an), 'hf);
    chk("arst_seg", int'(seg), 'h7f);
    chk("arst_pos", int'(pos), 0);
    chk("arst_wrap", int'(wrap), 0);
    en = 1'b0;
    @(posedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    chk("restart_an", int'(an), 'he);
    chk("restart_seg", int'(seg), int'(C_H));
    chk("restart_pos", int'(pos), 0);
    #1;

    for (int k = 0; k < 3000; k++) begin
      en    = ($urandom_range(0, 3) != 0);
      dir   = $urandom_range(0, 1) != 0;
      blank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0;
        @(posedge clk); #2 rstn = 1'b1;
      end
      @(posedge clk); #2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
